// File: rtl/multi_alarm_clock.sv
// Multi-channel alarm unit: per-channel settable alarm time, arm bit and ring/snooze FSM with ring timeout.
// Snooze support is compiled in only when MULTI_ALARM_SNOOZE_EN is defined.
module multi_alarm_clock #(
    parameter int N_ALARMS   = 4,
    parameter int HOUR       = 24,
    parameter int MINUTE     = 60,
    parameter int SECOND     = 60,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300,
    localparam int SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sec_tick,
    input  logic [7:0]          cur_hour,
    input  logic [7:0]          cur_minute,
    input  logic [7:0]          cur_second,
    input  logic [N_ALARMS-1:0] arm,
    input  logic [SEL_W-1:0]    sel,
    input  logic [2:0]          signal_increase,
    input  logic [2:0]          signal_decrease,
    input  logic                reset_alarm,
    input  logic                snooze,
    output logic [7:0]          rd_hour,
    output logic [7:0]          rd_minute,
    output logic [7:0]          rd_second,
    output logic [N_ALARMS-1:0] ring_vec,
    output logic [N_ALARMS-1:0] snooze_vec,
    output logic                alarming
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZED = 2'd2;

    localparam int RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

    logic [7:0]        set_hour   [N_ALARMS];
    logic [7:0]        set_minute [N_ALARMS];
    logic [7:0]        set_second [N_ALARMS];
    logic [1:0]        state_q    [N_ALARMS];
    logic [1:0]        state_d    [N_ALARMS];
    logic [RING_W-1:0] ring_cnt_q [N_ALARMS];
    logic [RING_W-1:0] ring_cnt_d [N_ALARMS];
    logic [N_ALARMS-1:0] trig;
    logic              sel_ok;

`ifdef MULTI_ALARM_SNOOZE_EN
    localparam int SNZ_W = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    logic [SNZ_W-1:0]  snz_cnt_q [N_ALARMS];
    logic [SNZ_W-1:0]  snz_cnt_d [N_ALARMS];
`else
    logic              unused_snooze;
    assign unused_snooze = snooze;
    assign snooze_vec    = '0;
`endif

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input int modulus);
        return (int'(v) >= modulus - 1) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] wrap_dec(input logic [7:0] v, input int modulus);
        return (v == 8'd0) ? 8'(modulus - 1) : v - 8'd1;
    endfunction

    assign sel_ok = int'(sel) < N_ALARMS;

    // Alarm time editing; increase pulses take precedence over decrease pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                set_hour[i]   <= 8'd8;
                set_minute[i] <= 8'd0;
                set_second[i] <= 8'd0;
            end
        end else if (sel_ok) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (int'(sel) == i) begin
                    if (|signal_increase) begin
                        if (signal_increase[0]) set_second[i] <= wrap_inc(set_second[i], SECOND);
                        if (signal_increase[1]) set_minute[i] <= wrap_inc(set_minute[i], MINUTE);
                        if (signal_increase[2]) set_hour[i]   <= wrap_inc(set_hour[i], HOUR);
                    end else begin
                        if (signal_decrease[0]) set_second[i] <= wrap_dec(set_second[i], SECOND);
                        if (signal_decrease[1]) set_minute[i] <= wrap_dec(set_minute[i], MINUTE);
                        if (signal_decrease[2]) set_hour[i]   <= wrap_dec(set_hour[i], HOUR);
                    end
                end
            end
        end
    end

    always_comb begin
        rd_hour   = 8'd0;
        rd_minute = 8'd0;
        rd_second = 8'd0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (int'(sel) == i) begin
                rd_hour   = set_hour[i];
                rd_minute = set_minute[i];
                rd_second = set_second[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            trig[i] = sec_tick && arm[i] &&
                      ({cur_hour, cur_minute, cur_second} ==
                       {set_hour[i], set_minute[i], set_second[i]});
        end
    end

    // Per-channel next state, branches in priority order.
    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            state_d[i]    = state_q[i];
            ring_cnt_d[i] = ring_cnt_q[i];
`ifdef MULTI_ALARM_SNOOZE_EN
            snz_cnt_d[i]  = snz_cnt_q[i];
`endif
            if (!arm[i]) begin
                state_d[i] = ST_IDLE;
            end else if (reset_alarm && state_q[i] != ST_IDLE) begin
                state_d[i] = ST_IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
            end else if (snooze && state_q[i] == ST_RINGING) begin
                state_d[i]   = ST_SNOOZED;
                snz_cnt_d[i] = '0;
`endif
            end else if (trig[i] && state_q[i] != ST_RINGING) begin
                state_d[i]    = ST_RINGING;
                ring_cnt_d[i] = '0;
            end else if (state_q[i] == ST_RINGING && sec_tick) begin
                if (ring_cnt_q[i] == RING_W'(RING_SEC - 1)) begin
                    state_d[i] = ST_IDLE;
                end else begin
                    ring_cnt_d[i] = ring_cnt_q[i] + RING_W'(1);
                end
`ifdef MULTI_ALARM_SNOOZE_EN
            end else if (state_q[i] == ST_SNOOZED && sec_tick) begin
                if (snz_cnt_q[i] == SNZ_W'(SNOOZE_SEC - 1)) begin
                    state_d[i]    = ST_RINGING;
                    ring_cnt_d[i] = '0;
                end else begin
                    snz_cnt_d[i] = snz_cnt_q[i] + SNZ_W'(1);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ring_vec <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
            snooze_vec <= '0;
`endif
            for (int i = 0; i < N_ALARMS; i++) begin
                state_q[i]    <= ST_IDLE;
                ring_cnt_q[i] <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
                snz_cnt_q[i]  <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                state_q[i]    <= state_d[i];
                ring_cnt_q[i] <= ring_cnt_d[i];
                ring_vec[i]   <= (state_d[i] == ST_RINGING);
`ifdef MULTI_ALARM_SNOOZE_EN
                snz_cnt_q[i]  <= snz_cnt_d[i];
                snooze_vec[i] <= (state_d[i] == ST_SNOOZED);
`endif
            end
        end
    end

    assign alarming = |ring_vec;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Table-driven bench for multi_alarm_clock: each row is one clock cycle of inputs plus the outputs expected after it.
module tb_multi_alarm_clock;

`ifdef MULTI_ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0;
    logic [7:0] cur_hour = '0, cur_minute = '0, cur_second = '0;
    logic [3:0] arm = '0;
    logic [1:0] sel = '0;
    logic [2:0] signal_increase = '0, signal_decrease = '0;
    logic       reset_alarm = 1'b0, snooze = 1'b0;
    logic [7:0] rd_hour, rd_minute, rd_second;
    logic [3:0] ring_vec, snooze_vec;
    logic       alarming;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        rst_n;
        logic [1:0]  sel;
        logic [2:0]  inc;
        logic [2:0]  dec;
        logic [3:0]  arm;
        logic        tick;
        logic [23:0] cur;
        logic        ra;
        logic        snz;
        logic [23:0] exp_time;
        logic [3:0]  exp_ring;
        logic [3:0]  exp_snz;
    } vec_t;

    vec_t vecs[$];

    multi_alarm_clock #(
        .N_ALARMS(4), .HOUR(24), .MINUTE(60), .SECOND(60), .RING_SEC(3), .SNOOZE_SEC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .arm(arm), .sel(sel),
        .signal_increase(signal_increase), .signal_decrease(signal_decrease),
        .reset_alarm(reset_alarm), .snooze(snooze),
        .rd_hour(rd_hour), .rd_minute(rd_minute), .rd_second(rd_second),
        .ring_vec(ring_vec), .snooze_vec(snooze_vec), .alarming(alarming)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] tm(input int h, input int m, input int s);
        return {8'(h), 8'(m), 8'(s)};
    endfunction

    function automatic void add(input logic r, input logic [1:0] sl, input logic [2:0] inc,
                                input logic [2:0] dec, input logic [3:0] a, input logic t,
                                input logic [23:0] cur, input logic ra, input logic snz,
                                input logic [23:0] et, input logic [3:0] er, input logic [3:0] es);
        vec_t v;
        v.rst_n = r; v.sel = sl; v.inc = inc; v.dec = dec; v.arm = a; v.tick = t;
        v.cur = cur; v.ra = ra; v.snz = snz; v.exp_time = et; v.exp_ring = er; v.exp_snz = es;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int row, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    initial begin
        // Reset and readback of every channel.
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, tm(8, 0, 0), 0, 0);
        for (int sl = 1; sl < 4; sl++) add(1, 2'(sl), 0, 0, 0, 0, 0, 0, 0, tm(8, 0, 0), 0, 0);
        // Channel 1: hour down to 0, wrap to 23, second wrap both directions, precedence, multi-field.
        for (int k = 7; k >= 0; k--) add(1, 1, 0, 3'b100, 0, 0, 0, 0, 0, tm(k, 0, 0), 0, 0);
        add(1, 1, 0, 3'b100, 0, 0, 0, 0, 0, tm(23, 0, 0), 0, 0);
        add(1, 1, 0, 3'b001, 0, 0, 0, 0, 0, tm(23, 0, 59), 0, 0);
        add(1, 1, 3'b001, 0, 0, 0, 0, 0, 0, tm(23, 0, 0), 0, 0);
        add(1, 1, 3'b001, 3'b010, 0, 0, 0, 0, 0, tm(23, 0, 1), 0, 0);
        add(1, 1, 3'b111, 0, 0, 0, 0, 0, 0, tm(0, 1, 2), 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, tm(8, 0, 0), 0, 0);
        // Channels 0 and 2 set to 08:00:05.
        for (int k = 1; k <= 5; k++) add(1, 0, 3'b001, 0, 0, 0, 0, 0, 0, tm(8, 0, k), 0, 0);
        for (int k = 1; k <= 5; k++) add(1, 2, 3'b001, 0, 0, 0, 0, 0, 0, tm(8, 0, k), 0, 0);
        // Trigger two channels, then disarm channel 2.
        add(1, 0, 0, 0, 4'b0101, 1, tm(8, 0, 5), 0, 0, tm(8, 0, 5), 4'b0101, 0);
        add(1, 2, 0, 0, 4'b0001, 0, 0, 0, 0, tm(8, 0, 5), 4'b0001, 0);
        // Timeout after the third tick.
        add(1, 0, 0, 0, 4'b0001, 1, 0, 0, 0, tm(8, 0, 5), 4'b0001, 0);
        add(1, 0, 0, 0, 4'b0001, 0, 0, 0, 0, tm(8, 0, 5), 4'b0001, 0);
        add(1, 0, 0, 0, 4'b0001, 1, 0, 0, 0, tm(8, 0, 5), 4'b0001, 0);
        add(1, 0, 0, 0, 4'b0001, 1, 0, 0, 0, tm(8, 0, 5), 4'b0000, 0);
        // A second match while ringing must not restart the count.
        add(1, 0, 0, 0, 4'b0001, 1, tm(8, 0, 5), 0, 0, tm(8, 0, 5), 4'b0001, 0);
        add(1, 0, 0, 0, 4'b0001, 1, tm(8, 0, 5), 0, 0, tm(8, 0, 5), 4'b0001, 0);
        add(1, 0, 0, 0, 4'b0001, 1, 0, 0, 0, tm(8, 0, 5), 4'b0001, 0);
        add(1, 0, 0, 0, 4'b0001, 1, 0, 0, 0, tm(8, 0, 5), 4'b0000, 0);
        // Snooze, snooze expiry, snooze again, dismiss.
        add(1, 0, 0, 0, 4'b0001, 1, tm(8, 0, 5), 0, 0, tm(8, 0, 5), 4'b0001, 0);
        add(1, 0, 0, 0, 4'b0001, 0, 0, 0, 1, tm(8, 0, 5), SNZ_EN ? 4'b0000 : 4'b0001, SNZ_EN ? 4'b0001 : 4'b0000);
        add(1, 0, 0, 0, 4'b0001, 1, 0, 0, 0, tm(8, 0, 5), SNZ_EN ? 4'b0000 : 4'b0001, SNZ_EN ? 4'b0001 : 4'b0000);
        add(1, 0, 0, 0, 4'b0001, 1, 0, 0, 0, tm(8, 0, 5), 4'b0001, 0);
        add(1, 0, 0, 0, 4'b0001, 0, 0, 0, 1, tm(8, 0, 5), SNZ_EN ? 4'b0000 : 4'b0001, SNZ_EN ? 4'b0001 : 4'b0000);
        add(1, 0, 0, 0, 4'b0001, 0, 0, 1, 0, tm(8, 0, 5), 0, 0);
        // Dismiss while ringing.
        add(1, 0, 0, 0, 4'b0001, 1, tm(8, 0, 5), 0, 0, tm(8, 0, 5), 4'b0001, 0);
        add(1, 0, 0, 0, 4'b0001, 0, 0, 1, 0, tm(8, 0, 5), 0, 0);
        // Reset with two channels ringing, then match without and with sec_tick.
        add(1, 0, 0, 0, 4'b0101, 1, tm(8, 0, 5), 0, 0, tm(8, 0, 5), 4'b0101, 0);
        add(0, 2, 0, 0, 4'b0101, 0, 0, 0, 0, tm(8, 0, 0), 0, 0);
        add(1, 0, 0, 0, 4'b0101, 0, 0, 0, 0, tm(8, 0, 0), 0, 0);
        add(1, 0, 0, 0, 4'b0101, 0, tm(8, 0, 0), 0, 0, tm(8, 0, 0), 0, 0);
        add(1, 0, 0, 0, 4'b0101, 0, tm(8, 0, 0), 0, 1, tm(8, 0, 0), 0, 0);
        add(1, 0, 0, 0, 4'b0101, 1, tm(8, 0, 0), 0, 0, tm(8, 0, 0), 4'b0101, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            rst_n           = vecs[r].rst_n;
            sel             = vecs[r].sel;
            signal_increase = vecs[r].inc;
            signal_decrease = vecs[r].dec;
            arm             = vecs[r].arm;
            sec_tick        = vecs[r].tick;
            {cur_hour, cur_minute, cur_second} = vecs[r].cur;
            reset_alarm     = vecs[r].ra;
            snooze          = vecs[r].snz;
            @(posedge clk);
            #1;
            chk("rd_time", r, {rd_hour, rd_minute, rd_second}, vecs[r].exp_time);
            chk("ring_vec", r, 24'(ring_vec), 24'(vecs[r].exp_ring));
            chk("snooze_vec", r, 24'(snooze_vec), 24'(vecs[r].exp_snz));
            chk("alarming", r, 24'(alarming), 24'(|vecs[r].exp_ring));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
